// File: rtl/sha256_block_loader_pkg.sv
// Shared constants and state type for the SHA-256 message block loader.
package sha256_block_loader_pkg;

  localparam int DATA_W      = 8;
  localparam int BLOCK_BYTES = 64;
  localparam int BLOCK_W     = DATA_W * BLOCK_BYTES;
  localparam int CNT_W       = 6;
  localparam int LANE_IDX_W  = 9;

  // Counter value of the final byte of a block.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

  // FILL collects bytes, HOLD presents a complete block to the core.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

  // Bit offset of the lane for byte number cnt; byte 0 sits in the top byte.
  function automatic logic [LANE_IDX_W-1:0] lane_lsb(input logic [CNT_W-1:0] cnt);
    return {~cnt, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_block_loader_if.sv
// Byte-stream input and block handshake signals of the block loader.
interface sha256_block_loader_if;
  import sha256_block_loader_pkg::*;

  logic [DATA_W-1:0]  data;
  logic               write_enable;
  logic               first_block;
  logic               last_block;
  logic               busy;
  logic [BLOCK_W-1:0] block_data;
  logic               block_first;
  logic               block_last;
  logic               block_valid;
  logic               block_ready;
  logic               overrun;

  // Loader side.
  modport slave (
    input  data, write_enable, first_block, last_block, block_ready,
    output busy, block_data, block_first, block_last, block_valid, overrun
  );

  // Writer / core side.
  modport master (
    output data, write_enable, first_block, last_block, block_ready,
    input  busy, block_data, block_first, block_last, block_valid, overrun
  );

endinterface

// File: rtl/sha256_block_loader.sv
// Packs a byte stream into big-endian 512-bit blocks and hands each block
// to the compression core over a valid/ready handshake.
module sha256_block_loader
  import sha256_block_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sha256_block_loader_if.slave bus
);

  loader_state_e      r_state;
  loader_state_e      w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_block_data;
  logic               r_first;
  logic               r_last;
  logic               r_overrun;

  logic               w_accept;
  logic               w_drop;
  logic               w_last_byte;
  logic [LANE_IDX_W-1:0] w_lane_lsb;

  // Classify the current write: accepted while filling, dropped while holding.
  always_comb begin
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_last_byte = 1'b0;
    w_lane_lsb  = lane_lsb(r_cnt);
    if (r_state == FILL) begin
      w_accept    = bus.write_enable;
      w_last_byte = bus.write_enable && (r_cnt == LAST_CNT);
    end else begin
      w_drop = bus.write_enable;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave FILL on the 64th byte, leave HOLD on handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: begin
        if (w_last_byte) begin
          w_next_state = HOLD;
        end else begin
          w_next_state = FILL;
        end
      end
      HOLD: begin
        if (bus.block_ready) begin
          w_next_state = FILL;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  // Outputs come straight from registers; valid and busy both mean HOLD.
  always_comb begin
    bus.busy        = (r_state == HOLD);
    bus.block_valid = (r_state == HOLD);
    bus.block_data  = r_block_data;
    bus.block_first = r_first;
    bus.block_last  = r_last;
    bus.overrun     = r_overrun;
  end

  // Byte lanes, counter and block flags; the counter wraps to 0 on byte 63,
  // so it is already cleared for the next block while holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_block_data <= '0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
    end else if (w_accept) begin
      r_block_data[w_lane_lsb +: DATA_W] <= bus.data;
      r_cnt <= r_cnt + 6'd1;
      if (r_cnt == 6'd0) begin
        r_first <= bus.first_block;
        r_last  <= bus.last_block;
      end
    end
  end

  // Sticky flag for any byte written while the loader was busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

endmodule
